// File: rtl/ts_stub_adr_gen_pkg.sv
// Shared constants and channel state encoding for the stub address generator.
package ts_stub_adr_gen_pkg;

   localparam int unsigned CROSS_NUM_BUF_ADR_BITS = 4;
   localparam int unsigned STUB_ADR_BITS          = 10;
   localparam int unsigned N_CH_DEFAULT           = 4;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_t;

   // Low (in-crossing) address field width.
   function automatic int unsigned low_bits_of(input int unsigned adr_bits,
                                               input int unsigned cross_bits);
      return adr_bits - cross_bits;
   endfunction

endpackage

// File: rtl/ts_stub_adr_ch.sv
// One stub-address channel: loads a crossing window, then walks it one address per
// consumed beat, with clipping, busy-load rejection and flush.
module ts_stub_adr_ch #(
   parameter int unsigned CROSS_NUM_BITS = ts_stub_adr_gen_pkg::CROSS_NUM_BUF_ADR_BITS,
   parameter int unsigned STUB_ADR_BITS  = ts_stub_adr_gen_pkg::STUB_ADR_BITS,
   parameter int unsigned CNT_BITS       = STUB_ADR_BITS - CROSS_NUM_BITS + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      ld_en,
   input  logic [CROSS_NUM_BITS-1:0] cross_num,
   input  logic [CNT_BITS-1:0]       stub_cnt,
   input  logic                      adr_rdy,
   output logic [STUB_ADR_BITS-1:0]  stub_adr,
   output logic                      adr_vld,
   output logic                      adr_last,
   output logic                      busy,
   output logic                      done,
   output logic                      ld_err,
   output logic                      cnt_clip
);
   import ts_stub_adr_gen_pkg::*;

   localparam int unsigned LOW_BITS = low_bits_of(STUB_ADR_BITS, CROSS_NUM_BITS);
   localparam logic [CNT_BITS-1:0] WINDOW = CNT_BITS'(1) << LOW_BITS;

   ch_state_t                state_q, state_d;
   logic [STUB_ADR_BITS-1:0] adr_q, adr_d;
   logic [CNT_BITS-1:0]      rem_q, rem_d;
   logic                     last_q, last_d;
   logic                     done_q, done_d;
   logic                     ld_err_q, ld_err_d;
   logic                     clip_q, clip_d;
   logic [CNT_BITS-1:0]      cnt_eff;
   logic [LOW_BITS-1:0]      low_inc;

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= CH_IDLE;
         adr_q    <= '0;
         rem_q    <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         ld_err_q <= 1'b0;
         clip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         adr_q    <= adr_d;
         rem_q    <= rem_d;
         last_q   <= last_d;
         done_q   <= done_d;
         ld_err_q <= ld_err_d;
         clip_q   <= clip_d;
      end
   end

   // Next state, address, count and pulses; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      adr_d    = adr_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      ld_err_d = 1'b0;
      clip_d   = 1'b0;
      cnt_eff  = (stub_cnt > WINDOW) ? WINDOW : stub_cnt;
      low_inc  = adr_q[LOW_BITS-1:0] + LOW_BITS'(1);

      if (flush) begin
         state_d = CH_IDLE;
         rem_d   = '0;
      end else begin
         case (state_q)
            CH_IDLE: begin
               if (ld_en) begin
                  if (stub_cnt == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = CH_RUN;
                     adr_d   = {cross_num, LOW_BITS'(0)};
                     rem_d   = cnt_eff;
                     clip_d  = (stub_cnt > WINDOW);
                  end
               end
            end
            CH_RUN: begin
               ld_err_d = ld_en;
               if (adr_rdy) begin
                  if (rem_q == CNT_BITS'(1)) begin
                     state_d = CH_IDLE;
                     rem_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     // Only the in-crossing field advances; the crossing number is fixed.
                     adr_d = {adr_q[STUB_ADR_BITS-1:LOW_BITS], low_inc};
                     rem_d = rem_q - CNT_BITS'(1);
                  end
               end
            end
            default: state_d = CH_IDLE;
         endcase
      end

      last_d = (state_d == CH_RUN) && (rem_d == CNT_BITS'(1));
   end

   assign stub_adr = adr_q;
   assign adr_vld  = (state_q == CH_RUN);
   assign busy     = (state_q == CH_RUN);
   assign adr_last = last_q;
   assign done     = done_q;
   assign ld_err   = ld_err_q;
   assign cnt_clip = clip_q;

endmodule

// File: rtl/ts_stub_adr_gen.sv
// N_CH independent stub-address channels; this level only slices the flat buses.
module ts_stub_adr_gen #(
   parameter int unsigned N_CH           = ts_stub_adr_gen_pkg::N_CH_DEFAULT,
   parameter int unsigned CROSS_NUM_BITS = ts_stub_adr_gen_pkg::CROSS_NUM_BUF_ADR_BITS,
   parameter int unsigned STUB_ADR_BITS  = ts_stub_adr_gen_pkg::STUB_ADR_BITS,
   parameter int unsigned CNT_BITS       = STUB_ADR_BITS - CROSS_NUM_BITS + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush,
   input  logic [N_CH-1:0]                   ld_en,
   input  logic [N_CH*CROSS_NUM_BITS-1:0]    cross_num,
   input  logic [N_CH*CNT_BITS-1:0]          stub_cnt,
   input  logic [N_CH-1:0]                   adr_rdy,
   output logic [N_CH*STUB_ADR_BITS-1:0]     stub_adr,
   output logic [N_CH-1:0]                   adr_vld,
   output logic [N_CH-1:0]                   adr_last,
   output logic [N_CH-1:0]                   busy,
   output logic [N_CH-1:0]                   done,
   output logic [N_CH-1:0]                   ld_err,
   output logic [N_CH-1:0]                   cnt_clip
);
   import ts_stub_adr_gen_pkg::*;

   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      ts_stub_adr_ch #(
         .CROSS_NUM_BITS(CROSS_NUM_BITS),
         .STUB_ADR_BITS (STUB_ADR_BITS),
         .CNT_BITS      (CNT_BITS)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .flush    (flush),
         .ld_en    (ld_en[i]),
         .cross_num(cross_num[i*CROSS_NUM_BITS +: CROSS_NUM_BITS]),
         .stub_cnt (stub_cnt[i*CNT_BITS +: CNT_BITS]),
         .adr_rdy  (adr_rdy[i]),
         .stub_adr (stub_adr[i*STUB_ADR_BITS +: STUB_ADR_BITS]),
         .adr_vld  (adr_vld[i]),
         .adr_last (adr_last[i]),
         .busy     (busy[i]),
         .done     (done[i]),
         .ld_err   (ld_err[i]),
         .cnt_clip (cnt_clip[i])
      );
   end

endmodule

// File: tb/tb_ts_stub_adr_gen.sv
// Directed bench for ts_stub_adr_gen with hand-computed expected addresses and pulses.
module tb_ts_stub_adr_gen;
   localparam int N  = 4;
   localparam int CB = 4;
   localparam int AB = 10;
   localparam int KB = 7;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic [N-1:0]    ld_en;
   logic [N*CB-1:0] cross_num;
   logic [N*KB-1:0] stub_cnt;
   logic [N-1:0]    adr_rdy;
   logic [N*AB-1:0] stub_adr;
   logic [N-1:0]    adr_vld, adr_last, busy, done, ld_err, cnt_clip;

   int checks = 0;
   int errors = 0;

   ts_stub_adr_gen dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .ld_en(ld_en),
      .cross_num(cross_num), .stub_cnt(stub_cnt), .adr_rdy(adr_rdy),
      .stub_adr(stub_adr), .adr_vld(adr_vld), .adr_last(adr_last),
      .busy(busy), .done(done), .ld_err(ld_err), .cnt_clip(cnt_clip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ld(input int ch, input logic [CB-1:0] c, input logic [KB-1:0] n);
      ld_en[ch] = 1'b1;
      cross_num[ch*CB +: CB] = c;
      stub_cnt[ch*KB +: KB] = n;
   endtask

   function automatic logic [AB-1:0] adr_of(input int ch);
      return stub_adr[ch*AB +: AB];
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; flush = 1'b0; ld_en = '0; cross_num = '0; stub_cnt = '0; adr_rdy = '0;
      #12;
      checks++;
      if ({stub_adr, adr_vld, adr_last, busy, done, ld_err, cnt_clip} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: adr=%h vld=%b last=%b busy=%b done=%b err=%b clip=%b, want all 0",
                  stub_adr, adr_vld, adr_last, busy, done, ld_err, cnt_clip);
      end
      @(negedge clk) rst_n = 1'b1;
      step;
   endtask

   task automatic test_full_rate;
      logic [AB-1:0] e;
      set_ld(0, 4'd3, 7'd4); adr_rdy = 4'b0001;
      step; ld_en = '0;
      for (int k = 0; k < 4; k++) begin
         e = 10'h0C0 + AB'(k);
         checks++;
         if ({adr_vld[0], adr_last[0], busy[0], adr_of(0)} !== {1'b1, (k == 3), 1'b1, e}) begin
            errors++;
            $display("FAIL full_rate_beat%0d: vld=%b last=%b busy=%b adr=%h, want 1 %b 1 %h",
                     k, adr_vld[0], adr_last[0], busy[0], adr_of(0), (k == 3), e);
         end
         step;
      end
      checks++;
      if ({adr_vld[0], busy[0], done[0]} !== 3'b001) begin
         errors++;
         $display("FAIL full_rate_done: vld=%b busy=%b done=%b, want 0 0 1", adr_vld[0], busy[0], done[0]);
      end
      step;
      checks++;
      if (done[0] !== 1'b0) begin
         errors++;
         $display("FAIL full_rate_done_width: done=%b, want 0", done[0]);
      end
   endtask

   task automatic test_backpressure;
      int  idx = 0;
      logic r;
      set_ld(1, 4'd0, 7'd3); adr_rdy = '0;
      step; ld_en = '0;
      for (int k = 0; k < 20; k++) begin
         if (idx >= 3) break;
         checks++;
         if ({adr_vld[1], adr_last[1], adr_of(1)} !== {1'b1, (idx == 2), AB'(idx)}) begin
            errors++;
            $display("FAIL backpressure_cyc%0d: vld=%b last=%b adr=%h, want 1 %b %h",
                     k, adr_vld[1], adr_last[1], adr_of(1), (idx == 2), AB'(idx));
         end
         r = (k % 2 == 0);
         adr_rdy[1] = r;
         step;
         if (r) idx++;
      end
      adr_rdy[1] = 1'b0;
      checks++;
      if ({idx == 3, adr_vld[1], done[1]} !== 3'b101) begin
         errors++;
         $display("FAIL backpressure_end: consumed=%0d vld=%b done=%b, want 3 0 1", idx, adr_vld[1], done[1]);
      end
      step;
   endtask

   task automatic test_zero_and_clip;
      int n = 0;
      int lasts = 0;
      logic [AB-1:0] last_adr = '0;
      set_ld(2, 4'd6, 7'd0);
      step; ld_en = '0;
      checks++;
      if ({adr_vld[2], busy[2], done[2], cnt_clip[2]} !== 4'b0010) begin
         errors++;
         $display("FAIL zero_cnt: vld=%b busy=%b done=%b clip=%b, want 0 0 1 0",
                  adr_vld[2], busy[2], done[2], cnt_clip[2]);
      end
      step;
      set_ld(2, 4'd5, 7'd100); adr_rdy[2] = 1'b1;
      step; ld_en = '0;
      checks++;
      if ({cnt_clip[2], adr_vld[2], adr_of(2)} !== {2'b11, 10'h140}) begin
         errors++;
         $display("FAIL clip_load: clip=%b vld=%b adr=%h, want 1 1 140", cnt_clip[2], adr_vld[2], adr_of(2));
      end
      for (int k = 0; k < 80; k++) begin
         if (!adr_vld[2]) break;
         checks++;
         if (adr_of(2) !== 10'h140 + AB'(n)) begin
            errors++;
            $display("FAIL clip_seq%0d: adr=%h, want %h", n, adr_of(2), 10'h140 + AB'(n));
         end
         if (adr_last[2]) begin
            lasts++;
            last_adr = adr_of(2);
         end
         n++;
         step;
      end
      checks++;
      if (n != 64 || lasts != 1 || last_adr !== 10'h17F || done[2] !== 1'b1) begin
         errors++;
         $display("FAIL clip_count: n=%0d lasts=%0d last_adr=%h done=%b, want 64 1 17f 1",
                  n, lasts, last_adr, done[2]);
      end
      adr_rdy[2] = 1'b0;
      step;
   endtask

   task automatic test_ld_err;
      set_ld(3, 4'd7, 7'd5); adr_rdy[3] = 1'b1;
      step; ld_en = '0;
      checks++;
      if (adr_of(3) !== 10'h1C0) begin
         errors++;
         $display("FAIL ld_err_start: adr=%h, want 1c0", adr_of(3));
      end
      set_ld(3, 4'd2, 7'd3);
      step; ld_en = '0;
      checks++;
      if ({ld_err[3], busy[3], adr_of(3)} !== {2'b11, 10'h1C1}) begin
         errors++;
         $display("FAIL ld_err_pulse: err=%b busy=%b adr=%h, want 1 1 1c1", ld_err[3], busy[3], adr_of(3));
      end
      step;
      checks++;
      if ({ld_err[3], adr_of(3)} !== {1'b0, 10'h1C2}) begin
         errors++;
         $display("FAIL ld_err_clear: err=%b adr=%h, want 0 1c2", ld_err[3], adr_of(3));
      end
      adr_rdy[3] = 1'b0;
      step; step;
      checks++;
      if ({adr_vld[3], adr_last[3], adr_of(3)} !== {2'b10, 10'h1C2}) begin
         errors++;
         $display("FAIL ld_err_hold: vld=%b last=%b adr=%h, want 1 0 1c2", adr_vld[3], adr_last[3], adr_of(3));
      end
   endtask

   task automatic test_flush;
      set_ld(0, 4'd1, 7'd8); set_ld(1, 4'd2, 7'd8); set_ld(2, 4'd3, 7'd8);
      adr_rdy = '0;
      step; ld_en = '0;
      checks++;
      if (busy !== 4'hF) begin
         errors++;
         $display("FAIL flush_pre: busy=%b, want 1111", busy);
      end
      flush = 1'b1;
      step; flush = 1'b0;
      checks++;
      if ({busy, adr_vld, adr_last, done} !== 16'h0) begin
         errors++;
         $display("FAIL flush_idle: busy=%b vld=%b last=%b done=%b, want 0s", busy, adr_vld, adr_last, done);
      end
      flush = 1'b1;
      for (int i = 0; i < N; i++) set_ld(i, 4'(i), 7'd5);
      step; flush = 1'b0; ld_en = '0;
      checks++;
      if ({busy, done, ld_err, cnt_clip} !== 16'h0) begin
         errors++;
         $display("FAIL flush_vs_ld: busy=%b done=%b err=%b clip=%b, want 0s", busy, done, ld_err, cnt_clip);
      end
      step;
   endtask

   task automatic test_async_reset;
      set_ld(0, 4'd1, 7'd20); adr_rdy[0] = 1'b1;
      step; ld_en = '0;
      step;
      checks++;
      if ({busy[0], adr_of(0)} !== {1'b1, 10'h041}) begin
         errors++;
         $display("FAIL rst_pre: busy=%b adr=%h, want 1 041", busy[0], adr_of(0));
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({stub_adr, adr_vld, adr_last, busy, done} !== '0) begin
         errors++;
         $display("FAIL rst_async: adr=%h vld=%b last=%b busy=%b done=%b, want 0s",
                  stub_adr, adr_vld, adr_last, busy, done);
      end
      adr_rdy = '0;
      @(negedge clk) rst_n = 1'b1;
      step;
      checks++;
      if ({busy, done} !== 8'h0) begin
         errors++;
         $display("FAIL rst_after: busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_all_channels;
      logic [CB-1:0] c;
      logic [AB-1:0] e;
      int cnt;
      for (int i = 0; i < N; i++) set_ld(i, CB'(9 + i), KB'(2 + i));
      adr_rdy = 4'hF;
      step; ld_en = '0;
      for (int cyc = 0; cyc < 7; cyc++) begin
         for (int i = 0; i < N; i++) begin
            c = CB'(9 + i);
            cnt = 2 + i;
            e = {c, 6'(cyc)};
            checks++;
            if (cyc < cnt) begin
               if ({adr_vld[i], adr_last[i], done[i], adr_of(i)} !== {1'b1, (cyc == cnt - 1), 1'b0, e}) begin
                  errors++;
                  $display("FAIL all_ch%0d_cyc%0d: vld=%b last=%b done=%b adr=%h, want 1 %b 0 %h",
                           i, cyc, adr_vld[i], adr_last[i], done[i], adr_of(i), (cyc == cnt - 1), e);
               end
            end else if ({adr_vld[i], done[i]} !== {1'b0, (cyc == cnt)}) begin
               errors++;
               $display("FAIL all_ch%0d_cyc%0d_idle: vld=%b done=%b, want 0 %b",
                        i, cyc, adr_vld[i], done[i], (cyc == cnt));
            end
         end
         step;
      end
   endtask

   initial begin
      test_reset;
      test_full_rate;
      test_backpressure;
      test_zero_and_clip;
      test_ld_err;
      test_flush;
      test_async_reset;
      test_all_channels;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ts_stub_adr_gen.md
TS_STUB_ADR_GEN -- requirements
Module: ts_stub_adr_gen

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  N_CH  4  number of independent stub-address channels
  CROSS_NUM_BITS  4  crossing-number bits placed in address MSBs
  STUB_ADR_BITS  10  stub memory address width; LOW_BITS = STUB_ADR_BITS-CROSS_NUM_BITS
  CNT_BITS  LOW_BITS+1  stub-count width, so a full window of 2^LOW_BITS stubs is representable
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  fast processing clock, single clock domain
  rst_n  in  1  asynchronous, active-low reset
  flush  in  1  synchronous abort of all channels
  ld_en  in  N_CH  per-channel load strobe
  cross_num  in  N_CH*CROSS_NUM_BITS  per-channel crossing number; channel i in slice i
  stub_cnt  in  N_CH*CNT_BITS  per-channel number of stubs to fetch
  adr_rdy  in  N_CH  per-channel consumer ready
  stub_adr  out  N_CH*STUB_ADR_BITS  per-channel stub address
  adr_vld  out  N_CH  stub_adr valid
  adr_last  out  N_CH  final address of the crossing
  busy  out  N_CH  channel is sequencing
  done  out  N_CH  one-cycle pulse: crossing complete
  ld_err  out  N_CH  one-cycle pulse: load rejected while busy
  cnt_clip  out  N_CH  one-cycle pulse: stub_cnt exceeded window and was clipped

Function
REQ-003 Each channel SHALL be an independent FSM with states IDLE and RUN; channels share only clk, rst_n, flush.
REQ-004 In IDLE, adr_vld, adr_last, busy SHALL be 0.
REQ-005 IDLE with ld_en=1 and stub_cnt>0 SHALL, next cycle, enter RUN with stub_adr = {cross_num, LOW_BITS zeros}, remaining = stub_cnt, adr_vld=1 (1-cycle load-to-valid latency).
REQ-006 IDLE with ld_en=1 and stub_cnt=0 SHALL stay IDLE and pulse done the next cycle; no address is issued.
REQ-007 stub_cnt > 2^LOW_BITS SHALL be clipped to 2^LOW_BITS and cnt_clip pulsed the next cycle; addresses never leave the crossing's window.
REQ-008 In RUN, adr_vld SHALL be 1; an address is consumed in a cycle with adr_vld=1 and adr_rdy=1.
REQ-009 With adr_rdy=0, stub_adr, adr_last and remaining SHALL hold.
REQ-010 On consumption with remaining>1, stub_adr SHALL increment by 1 and remaining decrement by 1 next cycle (one address per cycle at full throughput).
REQ-011 adr_last SHALL equal (RUN and remaining==1), registered with stub_adr.
REQ-012 On consumption with remaining==1, the channel SHALL return to IDLE and pulse done next cycle.
REQ-013 ld_en in RUN SHALL be ignored (state, address, count unchanged) and ld_err pulsed next cycle.
REQ-014 flush=1 SHALL force every channel to IDLE next cycle, with no done pulse; flush wins over ld_en in the same cycle.
REQ-015 Address increment SHALL be in the LOW_BITS field only; upper bits stay at cross_num, no carry (bounded by REQ-007).
REQ-016 busy SHALL equal (state==RUN).

Reset
REQ-017 rst_n=0 SHALL asynchronously force all channels to IDLE and all outputs, stub_adr and remaining to 0; deassertion is synchronous to clk.
REQ-018 Reset asserted mid-RUN SHALL abandon the crossing, with no done pulse.

Structure
REQ-019 Default parameter values and FSM state encoding SHALL come from the shared constants package (CROSS_NUM_BUF_ADR_BITS, STUB_ADR_BITS).
REQ-020 One sub-module, ts_stub_adr_ch (single channel FSM and counter), SHALL be instantiated N_CH times in a generate loop; the top only slices buses.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - ch0 ld cross_num=3, stub_cnt=4, adr_rdy=1 -> stub_adr 0x0C0..0x0C3 on consecutive cycles, adr_last on 0x0C3, done pulse 1 cycle later.
  - ch1 stub_cnt=3, adr_rdy toggling 1/0 -> addresses 0x000,0x001,0x002 each held while rdy=0, no skips or duplicates.
  - ch2 stub_cnt=0 -> no adr_vld, done pulse next cycle; stub_cnt=100 (window 64) -> cnt_clip, exactly 64 addresses, last = {cross,6'h3F}.
  - ld_en on busy ch3 -> ld_err pulse, sequence continues unchanged; flush mid-run on all channels -> all IDLE next cycle, no done.
  - rst_n low mid-RUN, asynchronous to clk -> outputs 0 immediately; all 4 channels loaded together -> independent correct sequences.
